// File: rtl/io_fabric_if.sv
// Upstream Wishbone port of io_fabric: the bus master drives the request,
// the fabric returns read data and completion/error.
interface io_fabric_if #(
  parameter int unsigned ADR_W = 17
);
  logic             cyc_i;
  logic             stb_i;
  logic             we_i;
  logic [ADR_W-1:0] adr_i;
  logic [3:0]       sel_i;
  logic [31:0]      dat_i;
  logic [31:0]      dat_o;
  logic             ack_o;
  logic             err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/io_fabric.sv
// Wishbone IO fabric: decodes adr[15:12] into a local register block or one of
// NCH downstream channels, with bus-error timeout and interrupt aggregation.
module io_fabric #(
  parameter int unsigned NCH     = 12,
  parameter int unsigned ADR_W   = 17,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned NIRQ    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  io_fabric_if.slave        bus,
  output logic              s_cyc_o,
  output logic [NCH-1:0]    s_stb_o,
  output logic              s_we_o,
  output logic [ADR_W-1:0]  s_adr_o,
  output logic [3:0]        s_sel_o,
  output logic [31:0]       s_dat_o,
  input  logic [NCH*32-1:0] s_dat_i,
  input  logic [NCH-1:0]    s_ack_i,
  input  logic [NIRQ-1:0]   irq_i,
  output logic              irq_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t            state_q;
  logic [3:0]        sel_q;
  logic [CNT_W-1:0]  wait_q;
  logic [NIRQ-1:0]   mask_q;
  logic [31:0]       scratch_q;
  logic [15:0]       err_count_q;
  logic [3:0]        last_err_sel_q;

  logic              chan_hit;
  logic              chan_ack;
  logic [31:0]       chan_dat;
  logic [31:0]       local_rd;

  assign s_we_o  = bus.we_i;
  assign s_adr_o = bus.adr_i;
  assign s_sel_o = bus.sel_i;
  assign s_dat_o = bus.dat_i;
  assign s_cyc_o = (state_q == BUSY) && chan_hit;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Channel decode of the latched selector; strobes only while BUSY.
  always_comb begin
    chan_hit = 1'b0;
    chan_ack = 1'b0;
    chan_dat = '0;
    s_stb_o  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_q == 4'(k + 1)) begin
        chan_hit = 1'b1;
        chan_ack = s_ack_i[k];
        chan_dat = s_dat_i[32*k +: 32];
        if (state_q == BUSY) s_stb_o[k] = 1'b1;
      end
    end
  end

  always_comb begin
    local_rd = '0;
    case (bus.adr_i[3:2])
      2'd0: local_rd = 32'(irq_i & mask_q);
      2'd1: local_rd = 32'(mask_q);
      2'd2: local_rd = {12'h000, last_err_sel_q, err_count_q};
      2'd3: local_rd = scratch_q;
      default: local_rd = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      wait_q         <= '0;
      mask_q         <= '0;
      scratch_q      <= '0;
      err_count_q    <= '0;
      last_err_sel_q <= '0;
      bus.dat_o      <= '0;
      bus.ack_o      <= 1'b0;
      bus.err_o      <= 1'b0;
      irq_o          <= 1'b0;
    end else begin
      bus.ack_o <= 1'b0;
      bus.err_o <= 1'b0;
      irq_o     <= |(irq_i & mask_q);
      case (state_q)
        IDLE: begin
          if (bus.cyc_i && bus.stb_i) begin
            state_q <= BUSY;
            sel_q   <= bus.adr_i[15:12];
            wait_q  <= '0;
          end
        end
        BUSY: begin
          if (!bus.cyc_i) begin
            state_q <= IDLE;
          end else if (sel_q == 4'd0) begin
            state_q   <= DONE;
            bus.ack_o <= 1'b1;
            if (bus.we_i) begin
              case (bus.adr_i[3:2])
                2'd1:    mask_q    <= NIRQ'(byte_merge(32'(mask_q), bus.dat_i, bus.sel_i));
                2'd3:    scratch_q <= byte_merge(scratch_q, bus.dat_i, bus.sel_i);
                default: ;
              endcase
            end else begin
              bus.dat_o <= local_rd;
            end
          end else if (chan_hit && chan_ack) begin
            // An ack on the timeout cycle still completes normally.
            state_q   <= DONE;
            bus.ack_o <= 1'b1;
            if (!bus.we_i) bus.dat_o <= chan_dat;
          end else if (!chan_hit || wait_q == CNT_W'(TIMEOUT - 1)) begin
            state_q        <= ERR;
            bus.err_o      <= 1'b1;
            last_err_sel_q <= sel_q;
            if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
            wait_q         <= wait_q + CNT_W'(1);
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_fabric.sv
// Randomized bench for io_fabric against a transaction-level register/bus model.
module tb_io_fabric;

  localparam int unsigned NCH     = 12;
  localparam int unsigned ADR_W   = 17;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned NIRQ    = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  io_fabric_if #(.ADR_W(ADR_W)) bus ();

  logic              s_cyc_o;
  logic [NCH-1:0]    s_stb_o;
  logic              s_we_o;
  logic [ADR_W-1:0]  s_adr_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_dat_o;
  logic [NCH*32-1:0] s_dat_i;
  logic [NCH-1:0]    s_ack_i;
  logic [NIRQ-1:0]   irq_i;
  logic              irq_o;

  io_fabric #(.NCH(NCH), .ADR_W(ADR_W), .TIMEOUT(TIMEOUT), .NIRQ(NIRQ)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .irq_i(irq_i), .irq_o(irq_o)
  );

  // Slave model: every channel acks on BUSY cycle ack_cyc (0 = never).
  logic [31:0] chan_data [NCH];
  int          ack_cyc = 0;
  int          busy_cnt = 0;

  always_comb begin
    for (int k = 0; k < NCH; k++) s_dat_i[32*k +: 32] = chan_data[k];
  end
  always @(posedge clk_i) busy_cnt <= s_cyc_o ? busy_cnt + 1 : 0;
  assign s_ack_i = (s_cyc_o && ack_cyc != 0 && busy_cnt + 1 == ack_cyc) ? s_stb_o : '0;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference state
  logic [31:0] m_scratch, m_mask, m_dat;
  int          m_err_cnt;
  logic [3:0]  m_last_sel;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_scratch = '0; m_mask = '0; m_dat = '0; m_err_cnt = 0; m_last_sel = '0;
  endtask

  task automatic access(input logic we, input logic [3:0] sl, input logic [1:0] idx,
                        input logic [3:0] be, input logic [31:0] wd, input int ackc);
    logic [ADR_W-1:0] adr;
    logic [NCH-1:0]   exp_stb;
    logic [31:0]      nirq_mask;
    int               exp_lat, n;
    bit               exp_err, seen;
    adr       = ADR_W'({sl, 8'h00, idx, 2'b00});
    nirq_mask = 32'((64'd1 << NIRQ) - 1);
    exp_stb   = '0;
    exp_err   = 1'b0;
    if (sl == 4'd0) begin
      exp_lat = 2;
      if (we) begin
        if (idx == 2'd1) m_mask = merge(m_mask, wd, be) & nirq_mask;
        if (idx == 2'd3) m_scratch = merge(m_scratch, wd, be);
      end else begin
        case (idx)
          2'd0: m_dat = 32'(irq_i) & m_mask;
          2'd1: m_dat = m_mask;
          2'd2: m_dat = {12'h000, m_last_sel, 16'(m_err_cnt)};
          default: m_dat = m_scratch;
        endcase
      end
    end else if (int'(sl) <= NCH) begin
      exp_stb[int'(sl) - 1] = 1'b1;
      if (ackc >= 1 && ackc <= int'(TIMEOUT)) begin
        exp_lat = ackc + 1;
        if (!we) m_dat = chan_data[int'(sl) - 1];
      end else begin
        exp_lat = TIMEOUT + 1;
        exp_err = 1'b1;
      end
    end else begin
      exp_lat = 2;
      exp_err = 1'b1;
    end
    if (exp_err) begin
      if (m_err_cnt < 65535) m_err_cnt++;
      m_last_sel = sl;
    end

    ack_cyc    = ackc;
    bus.cyc_i  = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
    bus.adr_i  = adr;  bus.sel_i = be;   bus.dat_i = wd;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk_i); #1;
      n++;
      if (n == 1) begin
        check_eq("strobe", 32'(s_stb_o), 32'(exp_stb));
        check_eq("adr_pass", 32'(s_adr_o), 32'(adr));
      end
      if (bus.ack_o || bus.err_o) seen = 1'b1;
    end
    check_eq("latency", n, exp_lat);
    check_eq("ack", 32'(bus.ack_o), 32'(!exp_err));
    check_eq("err", 32'(bus.err_o), 32'(exp_err));
    check_eq("dat_o", bus.dat_o, m_dat);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(posedge clk_i); #1;
    check_eq("one_pulse", 32'(bus.ack_o | bus.err_o), 32'd0);
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < NCH; k++) chan_data[k] = '0;
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.adr_i = '0; bus.sel_i = '0; bus.dat_i = '0;
    irq_i = '0;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_dat", bus.dat_o, 32'h0);
    check_eq("rst_ack_err", 32'({bus.ack_o, bus.err_o}), 32'h0);
    check_eq("rst_irq", 32'(irq_o), 32'h0);
    check_eq("rst_stb", 32'(s_stb_o), 32'h0);
    rst_i = 1'b1;

    // Byte-selected scratch write and readback
    access(1'b1, 4'd0, 2'd3, 4'b0101, 32'hDEADBEEF, 0);
    access(1'b0, 4'd0, 2'd3, 4'b1111, 32'h0, 0);
    check_eq("scratch_rd", bus.dat_o, 32'h00AD00EF);

    // Channel read acked on 4th BUSY cycle
    chan_data[2] = 32'h12345678;
    access(1'b0, 4'd3, 2'd0, 4'b1111, 32'h0, 4);
    check_eq("chan_rd", bus.dat_o, 32'h12345678);

    // Timeout, then ack exactly on the timeout cycle
    access(1'b0, 4'd3, 2'd0, 4'b1111, 32'h0, 0);
    access(1'b0, 4'd0, 2'd2, 4'b1111, 32'h0, 0);
    check_eq("err_info", bus.dat_o, 32'h00030001);
    access(1'b0, 4'd3, 2'd0, 4'b1111, 32'h0, TIMEOUT);
    access(1'b0, 4'd0, 2'd2, 4'b1111, 32'h0, 0);
    check_eq("err_info_same", bus.dat_o, 32'h00030001);

    // Unmapped selector
    access(1'b0, 4'hF, 2'd0, 4'b1111, 32'h0, 1);
    access(1'b0, 4'd0, 2'd2, 4'b1111, 32'h0, 0);
    check_eq("err_info_unmap", bus.dat_o, 32'h000F0002);

    // Interrupt aggregation
    access(1'b1, 4'd0, 2'd1, 4'b1111, 32'h0000_0005, 0);
    irq_i = 8'h04;
    @(posedge clk_i); #1;
    check_eq("irq_on", 32'(irq_o), 32'd1);
    access(1'b0, 4'd0, 2'd0, 4'b1111, 32'h0, 0);
    check_eq("irq_stat", bus.dat_o, 32'h04);
    irq_i = 8'h02;
    @(posedge clk_i); #1;
    check_eq("irq_off", 32'(irq_o), 32'd0);

    // Abort by dropping cyc mid-BUSY
    ack_cyc = 0;
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = ADR_W'(17'h05000);
    repeat (3) @(posedge clk_i);
    #1;
    bus.cyc_i = 0; bus.stb_i = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      check_eq("abort_resp", 32'({bus.ack_o, bus.err_o}), 32'h0);
      check_eq("abort_stb", 32'(s_stb_o), 32'h0);
    end
    access(1'b0, 4'd0, 2'd2, 4'b1111, 32'h0, 0);

    // Reset mid-BUSY
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = ADR_W'(17'h05000);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check_eq("rst_mid_stb", 32'(s_stb_o), 32'h0);
    check_eq("rst_mid_resp", 32'({bus.ack_o, bus.err_o}), 32'h0);
    check_eq("rst_mid_dat", bus.dat_o, 32'h0);
    rst_i = 1'b1; bus.cyc_i = 0; bus.stb_i = 0;
    model_reset();
    access(1'b0, 4'd0, 2'd2, 4'b1111, 32'h0, 0);
    access(1'b0, 4'd0, 2'd3, 4'b1111, 32'h0, 0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      logic [3:0] sl;
      for (int k = 0; k < NCH; k++) chan_data[k] = $urandom;
      irq_i = NIRQ'($urandom);
      sl = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      access(1'($urandom), sl, 2'($urandom), 4'($urandom), $urandom,
             int'($urandom_range(0, TIMEOUT + 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
